// File: rtl/switch_onehot_conditioner.sv
// Synchronises, debounces and one-hot qualifies the raw slide switches for the index encoder.
// Optional macro SWITCH_PRIORITY_EN resolves multi-selections to the lowest-index set bit.
module switch_onehot_conditioner #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] RawSwitches,
  output logic [WIDTH-1:0] Switches,
  output logic             Valid,
  output logic             Changed,
  output logic             MultiError
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    SELECTED = 2'd1,
    FAULT    = 2'd2
  } state_t;

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] stable;
  logic [CNT_W-1:0] cnt [WIDTH];
  state_t           state;

  logic             is_zero;
  logic             is_multi;
  logic [WIDTH-1:0] sel;
  logic             sel_onehot;
  logic             sel_multi;

  // Two-flop synchroniser per switch
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= RawSwitches;
      sync_q    <= sync_meta;
    end
  end

  // Per-bit debounce: a level commits only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stable <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync_q[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= sync_q[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Classification of the committed vector; clearing the lowest set bit leaves a residue only for MULTI
  always_comb begin
    is_zero  = (stable == '0);
    is_multi = ((stable & (stable - WIDTH'(1))) != '0);
  end

`ifdef SWITCH_PRIORITY_EN
  always_comb begin
    sel        = stable & (~stable + WIDTH'(1));
    sel_onehot = !is_zero;
    sel_multi  = 1'b0;
  end
`else
  always_comb begin
    sel        = stable;
    sel_onehot = !is_zero && !is_multi;
    sel_multi  = is_multi;
  end
`endif

  // Selection FSM with registered outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= EMPTY;
      Switches   <= '0;
      Valid      <= 1'b0;
      Changed    <= 1'b0;
      MultiError <= 1'b0;
    end else begin
      Changed    <= 1'b0;
      MultiError <= is_multi;
      case (state)
        EMPTY: begin
          if (sel_onehot) begin
            state    <= SELECTED;
            Switches <= sel;
            Valid    <= 1'b1;
            Changed  <= 1'b1;
          end else if (sel_multi) begin
            state <= FAULT;
          end
        end
        SELECTED: begin
          if (sel_onehot) begin
            if (sel != Switches) begin
              Switches <= sel;
              Changed  <= 1'b1;
            end
          end else if (sel_multi) begin
            state <= FAULT;
            Valid <= 1'b0;
          end else begin
            state    <= EMPTY;
            Valid    <= 1'b0;
            Switches <= '0;
          end
        end
        FAULT: begin
          if (sel_onehot) begin
            state    <= SELECTED;
            Switches <= sel;
            Valid    <= 1'b1;
            Changed  <= 1'b1;
          end else if (!sel_multi) begin
            state    <= EMPTY;
            Switches <= '0;
          end
        end
        default: begin
          state    <= EMPTY;
          Switches <= '0;
          Valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule
